// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths and the data-memory arbiter state
// encoding.
package cpu_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic {
      S_ARB = 1'b0,
      S_ACK = 1'b1
   } arb_state_e;

   // The debug port has waited long enough and must win over the CPU.
   function automatic logic starved(input logic [7:0] cnt, input logic [7:0] limit);
      return (cnt == limit);
   endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage (priority)
// and a debug/DMA port whose waiting time is bounded by a starvation counter.
module dmem_port_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_re_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_stall_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   output logic              dbg_ack_o,
   output logic [DATA_W-1:0] dbg_rdata_o,
   output logic              mem_re_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam logic [7:0] STARVE_MAX_C = 8'(STARVE_MAX);

   arb_state_e        state_q, state_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              cpu_req_s;
   logic              dbg_gnt_s;

   assign cpu_req_s = cpu_re_i | cpu_we_i;

   // Debug grant: only from S_ARB, when the CPU is idle or the debug port is starved.
   always_comb begin
      dbg_gnt_s = 1'b0;
      if (state_q == S_ARB) begin
         dbg_gnt_s = dbg_req_i & (~cpu_req_s | starved(wait_cnt_q, STARVE_MAX_C));
      end else begin
         dbg_gnt_s = 1'b0;
      end
   end

   // Next state: a grant always costs exactly one acknowledge cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ARB: begin
            if (dbg_gnt_s) begin
               state_d = S_ACK;
            end else begin
               state_d = S_ARB;
            end
         end
         S_ACK:   state_d = S_ARB;
         default: state_d = S_ARB;
      endcase
   end

   // Starvation counter also runs during S_ACK so a held request keeps ageing.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!dbg_req_i || dbg_gnt_s) begin
         wait_cnt_d = 8'd0;
      end else if (wait_cnt_q < STARVE_MAX_C) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
   end

   // Debug read data is captured only on a granted read.
   always_comb begin
      dbg_rdata_d = dbg_rdata_q;
      if (dbg_gnt_s && !dbg_we_i) begin
         dbg_rdata_d = mem_rdata_i;
      end else begin
         dbg_rdata_d = dbg_rdata_q;
      end
   end

   // Memory mux: exactly one source drives the memory strobes in any cycle.
   always_comb begin
      mem_re_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
      if (dbg_gnt_s) begin
         mem_re_o    = ~dbg_we_i;
         mem_we_o    = dbg_we_i;
         mem_addr_o  = dbg_addr_i;
         mem_wdata_o = dbg_wdata_i;
      end else begin
         mem_re_o    = cpu_re_i;
         mem_we_o    = cpu_we_i;
         mem_addr_o  = cpu_addr_i;
         mem_wdata_o = cpu_wdata_i;
      end
   end

   // State, counter and debug read-data registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= S_ARB;
         wait_cnt_q  <= 8'd0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign cpu_stall_o = cpu_req_s & dbg_gnt_s;
   assign cpu_rdata_o = mem_rdata_i;
   assign dbg_ack_o   = (state_q == S_ACK);
   assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: reset-time mux table, CPU/debug sequences, contention,
// reset during a grant, and a STARVE_MAX=1 instance; debug read data is scoreboarded.
module tb_dmem_port_arbiter;

   logic        clk;
   logic        rst_i;
   logic        cpu_re, cpu_we, dbg_req, dbg_we;
   logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_stall, dbg_ack, mem_re, mem_we;

   logic        b_cpu_re, b_cpu_we, b_dbg_req, b_dbg_we;
   logic [31:0] b_cpu_addr, b_cpu_wdata, b_dbg_addr, b_dbg_wdata;
   logic [31:0] b_cpu_rdata, b_dbg_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic        b_cpu_stall, b_dbg_ack, b_mem_re, b_mem_we;

   logic [31:0] mem [0:15];
   logic [31:0] sb_q [$];
   int          total = 0;
   int          bad   = 0;

   typedef struct {
      logic        cre, cwe, dreq, dwe;
      logic        e_stall, e_re, e_we;
      logic [31:0] e_addr;
   } vec_t;
   vec_t tv [7];

   dmem_port_arbiter dut (
      .clk_i(clk), .rst_i(rst_i),
      .cpu_re_i(cpu_re), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
      .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata),
      .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
   );

   dmem_port_arbiter #(.STARVE_MAX(1)) dut1 (
      .clk_i(clk), .rst_i(rst_i),
      .cpu_re_i(b_cpu_re), .cpu_we_i(b_cpu_we), .cpu_addr_i(b_cpu_addr), .cpu_wdata_i(b_cpu_wdata),
      .cpu_rdata_o(b_cpu_rdata), .cpu_stall_o(b_cpu_stall),
      .dbg_req_i(b_dbg_req), .dbg_we_i(b_dbg_we), .dbg_addr_i(b_dbg_addr), .dbg_wdata_i(b_dbg_wdata),
      .dbg_ack_o(b_dbg_ack), .dbg_rdata_o(b_dbg_rdata),
      .mem_re_o(b_mem_re), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
      .mem_rdata_i(b_mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata   = mem[mem_addr[5:2]];
   assign b_mem_rdata = 32'h0000_0000;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sb_check();
      logic [31:0] e;
      if (dbg_ack === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_ack: got ack=1 expected no ack");
         end else begin
            e = sb_q.pop_front();
            chk("sb_dbg_rdata", dbg_rdata, e);
         end
      end
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      sb_check();
   endtask

   task automatic set_cpu(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
      cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic set_dbg(input logic rq, input logic we, input logic [31:0] a, input logic [31:0] d);
      dbg_req = rq; dbg_we = we; dbg_addr = a; dbg_wdata = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      rst_i = 1'b0;
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
      b_cpu_re = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = 32'h20; b_cpu_wdata = 32'h0;
      b_dbg_req = 1'b0; b_dbg_we = 1'b0; b_dbg_addr = 32'h24; b_dbg_wdata = 32'h0;

      // Reset held: state S_ARB, wait_cnt 0, so the mux is purely combinational.
      tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h30};
      tv[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h30};
      tv[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h30};
      tv[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h34};
      tv[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h34};
      tv[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h30};
      tv[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h30};
      for (int i = 0; i < 7; i++) begin
         drive_edge();
         set_cpu(tv[i].cre, tv[i].cwe, 32'h30, 32'h0);
         set_dbg(tv[i].dreq, tv[i].dwe, 32'h34, 32'h0);
         sample();
         chk($sformatf("tv%0d_stall", i), {31'd0, cpu_stall}, {31'd0, tv[i].e_stall});
         chk($sformatf("tv%0d_re", i), {31'd0, mem_re}, {31'd0, tv[i].e_re});
         chk($sformatf("tv%0d_we", i), {31'd0, mem_we}, {31'd0, tv[i].e_we});
         chk($sformatf("tv%0d_addr", i), mem_addr, tv[i].e_addr);
         chk($sformatf("tv%0d_ack", i), {31'd0, dbg_ack}, 32'd0);
      end
      chk("rst_dbg_rdata", dbg_rdata, 32'h0);

      drive_edge();
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
      rst_i = 1'b1;
      sample();
      chk("idle_ack", {31'd0, dbg_ack}, 32'd0);

      // 1: CPU store then load of the same word.
      drive_edge();
      set_cpu(1'b0, 1'b1, 32'h8, 32'h1234);
      sample();
      chk("t1_sw_we", {31'd0, mem_we}, 32'd1);
      chk("t1_sw_stall", {31'd0, cpu_stall}, 32'd0);
      drive_edge();
      set_cpu(1'b1, 1'b0, 32'h8, 32'h0);
      sample();
      chk("t1_lw_we", {31'd0, mem_we}, 32'd0);
      chk("t1_lw_rdata", cpu_rdata, 32'h1234);
      chk("t1_lw_stall", {31'd0, cpu_stall}, 32'd0);

      // 2: debug write then read, request held across the ack.
      drive_edge();
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_dbg(1'b1, 1'b1, 32'h4, 32'hA5);
      sb_q.push_back(32'h0);
      sample();
      chk("t2_wr_we", {31'd0, mem_we}, 32'd1);
      chk("t2_wr_addr", mem_addr, 32'h4);
      chk("t2_wr_ack", {31'd0, dbg_ack}, 32'd0);
      drive_edge();
      set_dbg(1'b1, 1'b0, 32'h4, 32'h0);
      sb_q.push_back(32'hA5);
      sample();
      chk("t2_ack1", {31'd0, dbg_ack}, 32'd1);
      chk("t2_ack1_re", {31'd0, mem_re}, 32'd0);
      drive_edge();
      sample();
      chk("t2_rd_re", {31'd0, mem_re}, 32'd1);
      chk("t2_rd_ack", {31'd0, dbg_ack}, 32'd0);
      drive_edge();
      set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      chk("t2_ack2", {31'd0, dbg_ack}, 32'd1);

      // 3: CPU loads every cycle while a debug read waits for starvation.
      drive_edge();
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
      set_dbg(1'b1, 1'b0, 32'h8, 32'h0);
      sb_q.push_back(32'h1234);
      for (int i = 1; i <= 6; i++) begin
         sample();
         chk($sformatf("t3_c%0d_stall", i), {31'd0, cpu_stall}, {31'd0, (i == 5)});
         chk($sformatf("t3_c%0d_ack", i), {31'd0, dbg_ack}, {31'd0, (i == 6)});
         chk($sformatf("t3_c%0d_addr", i), mem_addr, (i == 5) ? 32'h8 : 32'h10);
         drive_edge();
      end
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
      sample();

      // 4: CPU idle when the debug write arrives -> immediate grant.
      drive_edge();
      set_dbg(1'b1, 1'b1, 32'hC, 32'h77);
      sb_q.push_back(32'h1234);
      sample();
      chk("t4_we", {31'd0, mem_we}, 32'd1);
      chk("t4_addr", mem_addr, 32'hC);
      chk("t4_stall", {31'd0, cpu_stall}, 32'd0);
      drive_edge();
      set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
      set_cpu(1'b1, 1'b0, 32'hC, 32'h0);
      sample();
      chk("t4_ack", {31'd0, dbg_ack}, 32'd1);
      chk("t4_cpu_rdata", cpu_rdata, 32'h77);
      chk("t4_ack_stall", {31'd0, cpu_stall}, 32'd0);

      // 5: reset in the grant cycle drops the ack; master then re-issues.
      drive_edge();
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_dbg(1'b1, 1'b0, 32'hC, 32'h0);
      sample();
      chk("t5_gnt_re", {31'd0, mem_re}, 32'd1);
      #1 rst_i = 1'b0;
      drive_edge();
      rst_i = 1'b1;
      set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      chk("t5_no_ack", {31'd0, dbg_ack}, 32'd0);
      chk("t5_rdata_rst", dbg_rdata, 32'h0);
      drive_edge();
      set_dbg(1'b1, 1'b0, 32'hC, 32'h0);
      sb_q.push_back(32'h77);
      sample();
      chk("t5_regnt_re", {31'd0, mem_re}, 32'd1);
      drive_edge();
      set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      chk("t5_reack", {31'd0, dbg_ack}, 32'd1);

      // 6: STARVE_MAX=1, CPU always loading, master re-requests once its ack ends.
      b_cpu_re = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive_edge();
         b_dbg_req = ~b_dbg_ack;
         sample();
         chk($sformatf("t6_c%0d_stall", i), {31'd0, b_cpu_stall}, {31'd0, (i % 3 == 1)});
         chk($sformatf("t6_c%0d_ack", i), {31'd0, b_dbg_ack}, {31'd0, (i % 3 == 2)});
      end
      drive_edge();
      b_cpu_re = 1'b0;
      b_dbg_req = 1'b0;
      sample();

      chk("sb_empty", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
